// File: rtl/code2421_pkg.sv
// rtl/code2421_pkg.sv - shared types and code constants for the 2421 checker
package code2421_pkg;

  localparam int BCD_W = 4;

  typedef enum logic {
    UNLOCKED = 1'b0,
    LOCKED   = 1'b1
  } state_t;

  localparam logic [3:0] CODE_0 = 4'b0000;
  localparam logic [3:0] CODE_1 = 4'b0001;
  localparam logic [3:0] CODE_2 = 4'b0010;
  localparam logic [3:0] CODE_3 = 4'b0011;
  localparam logic [3:0] CODE_4 = 4'b0100;
  localparam logic [3:0] CODE_5 = 4'b1011;
  localparam logic [3:0] CODE_6 = 4'b1100;
  localparam logic [3:0] CODE_7 = 4'b1101;
  localparam logic [3:0] CODE_8 = 4'b1110;
  localparam logic [3:0] CODE_9 = 4'b1111;

  // Decimal successor with 9 wrapping to 0
  function automatic logic [BCD_W-1:0] next_digit(input logic [BCD_W-1:0] d);
    return (d == BCD_W'(9)) ? '0 : d + BCD_W'(1);
  endfunction

endpackage

// File: rtl/code2421_decode.sv
// rtl/code2421_decode.sv - combinational 2421 to BCD decoder with legality flag
module code2421_decode
  import code2421_pkg::*;
(
  input  logic [3:0]       code,
  output logic             legal,
  output logic [BCD_W-1:0] digit
);

  always_comb begin
    legal = 1'b1;
    digit = '0;
    case (code)
      CODE_0:  digit = BCD_W'(0);
      CODE_1:  digit = BCD_W'(1);
      CODE_2:  digit = BCD_W'(2);
      CODE_3:  digit = BCD_W'(3);
      CODE_4:  digit = BCD_W'(4);
      CODE_5:  digit = BCD_W'(5);
      CODE_6:  digit = BCD_W'(6);
      CODE_7:  digit = BCD_W'(7);
      CODE_8:  digit = BCD_W'(8);
      CODE_9:  digit = BCD_W'(9);
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/code2421_checker.sv
// rtl/code2421_checker.sv - 2421 digit stream decoder with sequence lock and error counting
module code2421_checker
  import code2421_pkg::*;
#(
  parameter int LOCK_THRESH = 3,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       code_in,
  input  logic             code_valid,
  input  logic             clr_err,
  output logic [BCD_W-1:0] bcd_out,
  output logic             bcd_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int MC_W = 4;
  localparam logic [MC_W-1:0] THRESH = MC_W'(LOCK_THRESH);

  logic             legal;
  logic [BCD_W-1:0] digit;

  state_t           state_q, state_d;
  logic [MC_W-1:0]  mcnt_q, mcnt_d;
  logic [BCD_W-1:0] exp_q, exp_d;
  logic [BCD_W-1:0] bcd_q, bcd_d;
  logic             bv_q, bv_d;
  logic             ce_q, ce_d;
  logic             se_q, se_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             err_evt;

  code2421_decode u_decode (
    .code  (code_in),
    .legal (legal),
    .digit (digit)
  );

  always_comb begin
    state_d = state_q;
    mcnt_d  = mcnt_q;
    exp_d   = exp_q;
    bcd_d   = bcd_q;
    bv_d    = 1'b0;
    ce_d    = 1'b0;
    se_d    = 1'b0;
    err_evt = 1'b0;
    err_d   = err_q;

    if (code_valid) begin
      if (!legal) begin
        ce_d    = 1'b1;
        state_d = UNLOCKED;
        mcnt_d  = '0;
      end else begin
        bcd_d = digit;
        bv_d  = 1'b1;
        exp_d = next_digit(digit);
        case (state_q)
          LOCKED: begin
            if (digit != exp_q) begin
              se_d    = 1'b1;
              state_d = UNLOCKED;
              mcnt_d  = MC_W'(1);
            end
          end
          default: begin
            // A fresh run (count 0) accepts any digit as its seed
            if (mcnt_q == '0 || digit == exp_q)
              mcnt_d = (mcnt_q >= THRESH) ? THRESH : mcnt_q + MC_W'(1);
            else
              mcnt_d = MC_W'(1);
            if (mcnt_d >= THRESH)
              state_d = LOCKED;
          end
        endcase
      end
    end

    err_evt = ce_d | se_d;
    if (clr_err)
      err_d = err_evt ? CNT_W'(1) : '0;
    else if (err_evt && err_q != '1)
      err_d = err_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= UNLOCKED;
      mcnt_q  <= '0;
      exp_q   <= '0;
      bcd_q   <= '0;
      bv_q    <= 1'b0;
      ce_q    <= 1'b0;
      se_q    <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      mcnt_q  <= mcnt_d;
      exp_q   <= exp_d;
      bcd_q   <= bcd_d;
      bv_q    <= bv_d;
      ce_q    <= ce_d;
      se_q    <= se_d;
      err_q   <= err_d;
    end
  end

  assign bcd_out   = bcd_q;
  assign bcd_valid = bv_q;
  assign code_err  = ce_q;
  assign seq_err   = se_q;
  assign locked    = (state_q == LOCKED);
  assign err_cnt   = err_q;

endmodule

// File: tb/tb_code2421_checker.sv
// tb/tb_code2421_checker.sv - scoreboard bench for code2421_checker
module tb_code2421_checker;

  localparam int THRESH  = 3;
  localparam int CW      = 2;
  localparam int ERR_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic [3:0]    code_in;
  logic          code_valid;
  logic          clr_err;
  logic [3:0]    bcd_out;
  logic          bcd_valid;
  logic          code_err;
  logic          seq_err;
  logic          locked;
  logic [CW-1:0] err_cnt;

  code2421_checker #(.LOCK_THRESH(THRESH), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .code_in    (code_in),
    .code_valid (code_valid),
    .clr_err    (clr_err),
    .bcd_out    (bcd_out),
    .bcd_valid  (bcd_valid),
    .code_err   (code_err),
    .seq_err    (seq_err),
    .locked     (locked),
    .err_cnt    (err_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit bv;
    bit ce;
    bit se;
  } exp_t;

  exp_t q[$];
  int   enc[10];
  int   dec[16];
  int   m_bcd, m_exp, m_cnt, m_err;
  bit   m_lk;
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic void chk(string name, int act, int expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  task automatic model_reset();
    m_bcd = 0; m_exp = 0; m_cnt = 0; m_err = 0; m_lk = 0;
    q.delete();
  endtask

  // Drive one cycle of inputs and advance the reference model for that edge
  task automatic step(input bit v, input int code, input bit clr);
    exp_t e;
    int   d;
    bit   ev;
    @(negedge clk);
    code_valid = v;
    code_in    = code[3:0];
    clr_err    = clr;
    e  = '{bv: 0, ce: 0, se: 0};
    ev = 0;
    if (v) begin
      d = dec[code[3:0]];
      if (d < 0) begin
        e.ce = 1; ev = 1; m_lk = 0; m_cnt = 0;
      end else begin
        m_bcd = d; e.bv = 1;
        if (m_lk) begin
          if (d != m_exp) begin
            e.se = 1; ev = 1; m_lk = 0; m_cnt = 1;
          end
        end else begin
          if (m_cnt == 0 || d == m_exp) m_cnt = (m_cnt + 1 > THRESH) ? THRESH : m_cnt + 1;
          else m_cnt = 1;
          if (m_cnt == THRESH) m_lk = 1;
        end
        m_exp = (d + 1) % 10;
      end
      q.push_back(e);
    end
    if (clr) m_err = ev ? 1 : 0;
    else if (ev) m_err = (m_err + 1 > ERR_MAX) ? ERR_MAX : m_err + 1;
  endtask

  task automatic digit(input int d);
    step(1, enc[d], 0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic async_reset();
    @(negedge clk);
    code_valid = 0;
    clr_err    = 0;
    #3 rst = 0;
    model_reset();
    #1;
    chk("async_rst_bcd_out", bcd_out, 0);
    chk("async_rst_bcd_valid", bcd_valid, 0);
    chk("async_rst_code_err", code_err, 0);
    chk("async_rst_seq_err", seq_err, 0);
    chk("async_rst_locked", locked, 0);
    chk("async_rst_err_cnt", err_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  // Monitor: state checked every cycle, pulses checked against the scoreboard queue
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      chk("locked", locked, m_lk);
      chk("err_cnt", err_cnt, m_err);
      chk("bcd_out", bcd_out, m_bcd);
      chk("code_seq_exclusive", code_err & seq_err, 0);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("bcd_valid", bcd_valid, e.bv);
        chk("code_err", code_err, e.ce);
        chk("seq_err", seq_err, e.se);
      end else if (bcd_valid || code_err || seq_err) begin
        chk("spurious_pulse", {bcd_valid, code_err, seq_err}, 0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r, v, c;
    rst = 0; code_valid = 0; code_in = 0; clr_err = 0;
    for (int i = 0; i < 16; i++) dec[i] = -1;
    enc = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF};
    for (int i = 0; i < 10; i++) dec[enc[i]] = i;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1;

    digit(0); digit(1); digit(2);
    for (int i = 3; i <= 9; i++) digit(i);
    digit(0);
    digit(1); digit(2);
    step(1, 4'b0101, 0);
    digit(3); digit(4); digit(5);
    digit(8); digit(9); digit(0);

    for (int i = 0; i < 5; i++) step(1, 5 + (i % 6), 0);
    step(1, 4'b1000, 1);
    step(0, 0, 1);
    step(1, 4'b1010, 0);
    step(0, 0, 0);
    step(0, 0, 1);

    digit(1); digit(2); digit(3);
    idle(2);
    async_reset();
    idle(2);
    digit(5); idle(1); digit(6); digit(7); digit(8);

    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0) ? 1 : 0;
      r = $urandom_range(0, 9);
      if (r < 6)      c = enc[m_exp];
      else if (r < 8) c = enc[$urandom_range(0, 9)];
      else            c = $urandom_range(0, 15);
      step(v[0], c, ($urandom_range(0, 19) == 0));
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    idle(3);
    chk("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/code2421_checker.md
CODE2421_CHECKER -- requirements
Module: code2421_checker

Interface
REQ-001 The block SHALL have parameter LOCK_THRESH, default 3: consecutive in-sequence legal digits required to enter LOCKED (range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 8: width of the error counter.
REQ-003 The block SHALL have one clock and an asynchronous active-low reset:
  clk        input   1      rising-edge clock
  rst        input   1      asynchronous reset, active-low
  code_in    input   4      2421-coded decimal digit
  code_valid input   1      code_in is sampled on this clock edge
  clr_err    input   1      synchronous clear of err_cnt
  bcd_out    output  4      decoded BCD digit, registered
  bcd_valid  output  1      one-cycle pulse: bcd_out updated
  code_err   output  1      one-cycle pulse: illegal 2421 code received
  seq_err    output  1      one-cycle pulse: legal digit out of sequence while LOCKED
  locked     output  1      high while FSM is in LOCKED
  err_cnt    output  CNT_W  saturating count of code_err plus seq_err events

Function
REQ-004 Legal code map SHALL be 0000->0, 0001->1, 0010->2, 0011->3, 0100->4, 1011->5, 1100->6, 1101->7, 1110->8, 1111->9; 0101, 0110, 0111, 1000, 1001, 1010 SHALL be illegal.
REQ-005 All outputs SHALL be registered; latency from a code_valid edge to bcd_valid/code_err/seq_err SHALL be exactly 1 cycle.
REQ-006 code_valid low SHALL hold bcd_out, expected digit, match count and state; pulses SHALL be 0.
REQ-007 Legal sample: bcd_out <= decoded digit, bcd_valid <= 1; illegal sample: bcd_out held, bcd_valid <= 0, code_err <= 1.
REQ-008 Expected digit SHALL be held as 4-bit BCD; after each legal sample expected <= (digit == 9) ? 0 : digit+1.
REQ-009 FSM states SHALL be UNLOCKED and LOCKED only.
REQ-010 UNLOCKED, legal sample: if match count is 0 or digit equals expected, match count +1 (saturating at LOCK_THRESH); otherwise match count <= 1 (re-seed on this digit).
REQ-011 UNLOCKED -> LOCKED SHALL occur on the sample that makes match count reach LOCK_THRESH; locked rises in the same registered update.
REQ-012 LOCKED, legal digit equal to expected: stay LOCKED, no error.
REQ-013 LOCKED, legal digit not equal to expected: seq_err <= 1, err_cnt +1, -> UNLOCKED, match count <= 1, expected re-seeded from this digit.
REQ-014 Illegal code in any state: code_err <= 1, err_cnt +1, -> UNLOCKED, match count <= 0, expected unchanged.
REQ-015 In UNLOCKED, out-of-sequence legal digits SHALL NOT assert seq_err.
REQ-016 Wrap-around 9 -> 0 SHALL count as in-sequence.
REQ-017 err_cnt SHALL saturate at all-ones and never wrap.
REQ-018 When clr_err and an error event occur on the same edge, err_cnt SHALL become 1; clr_err alone SHALL set err_cnt to 0.
REQ-019 code_err and seq_err SHALL never be high on the same cycle.

Reset
REQ-020 rst low SHALL asynchronously force: state UNLOCKED, locked 0, match count 0, expected 0, bcd_out 0000, bcd_valid 0, code_err 0, seq_err 0, err_cnt 0.
REQ-021 Reset asserted mid-stream SHALL discard lock; after release, LOCK_THRESH fresh in-sequence digits SHALL be required before locked rises.
REQ-022 Reset release SHALL be synchronized by the integrating level; the block SHALL sample no input on the edge that rst is low.

Structure
REQ-023 Package code2421_pkg SHALL hold the FSM state typedef, the ten legal 2421 code constants and a BCD width constant.
REQ-024 Sub-module code2421_decode SHALL be combinational: code_in -> {legal, digit[3:0]}; it SHALL be the only location of the code map.

Verification
REQ-025 Reset, then feed 0000,0001,0010 with code_valid every cycle -> locked rises 1 cycle after 0010 sampled; bcd_out 0,1,2; no errors.
REQ-026 Locked, feed 1111 then 0000 -> bcd_out 9 then 0, bcd_valid both cycles, locked stays 1, err_cnt 0.
REQ-027 Locked at expected 3, feed 0101 -> code_err pulse 1 cycle, bcd_valid 0, bcd_out holds 2, locked 0, err_cnt 1.
REQ-028 Locked at expected 6, feed 1110 (8) -> seq_err pulse, bcd_out 8, locked 0, err_cnt +1; then 9,0,1 -> locked again after the second digit following 8.
REQ-029 CNT_W=2, inject 5 illegal codes -> err_cnt 3 after third and stays 3; clr_err with simultaneous illegal code -> err_cnt 1.
REQ-030 Assert rst mid-stream while locked, gaps in code_valid before and after -> all outputs reset asynchronously, relock needs 3 fresh in-sequence digits.
